// File: rtl/sub32_serial.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit slice per RUN cycle,
// with registered borrow/overflow/zero flags and valid/ready handshakes.
//
// state | meaning
// IDLE  | ready_o=1, waiting for valid_i to latch operands
// RUN   | one nibble of the difference computed per edge
// DONE  | valid_o=1, result held until ready_i
module sub32_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] din1_i,
  input  logic [WIDTH-1:0] din2_i,
  input  logic             bin_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int STEPS = WIDTH / 4;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int MSB   = WIDTH - 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [SW-1:0]    step_q, step_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       nib_sum;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    step_d   = step_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    // Subtraction as a + ~b + ~borrow; carry-out of the slice is "no borrow".
    a_nib   = a_q[4*step_q +: 4];
    b_nib   = b_q[4*step_q +: 4];
    nib_sum = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, ~borrow_q};

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d      = din1_i;
          b_d      = din2_i;
          step_d   = '0;
          borrow_d = bin_i;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[4*step_q +: 4] = nib_sum[3:0];
        borrow_d              = ~nib_sum[4];
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = DONE;
          bout_d  = ~nib_sum[4];
          ovf_d   = (a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
          zero_d  = (diff_d == '0);
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      step_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      step_q   <= step_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign diff_o  = diff_q;
  assign bout_o  = bout_q;
  assign ovf_o   = ovf_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_sub32_serial.sv
// Bench for sub32_serial: arithmetic reference model with per-cycle comparison,
// directed corner vectors, backpressure, mid-operation reset and random traffic.
module tb_sub32_serial;

  localparam int WIDTH = 32;
  localparam int STEPS = WIDTH / 4;
  localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SMIN = -64'sh0000_0000_8000_0000;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_i = 1'b0;
  logic              bin_i = 1'b0;
  logic [WIDTH-1:0]  din1_i = '0;
  logic [WIDTH-1:0]  din2_i = '0;
  logic              ready_o, valid_o, bout_o, ovf_o, zero_o;
  logic [WIDTH-1:0]  diff_o;

  int checks = 0;
  int errors = 0;

  sub32_serial #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .din1_i  (din1_i),
    .din2_i  (din2_i),
    .bin_i   (bin_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .diff_o  (diff_o),
    .bout_o  (bout_o),
    .ovf_o   (ovf_o),
    .zero_o  (zero_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference arithmetic: unsigned and signed differences in 64-bit integers.
  function automatic void model_sub(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                    output logic [31:0] d, output logic bo, output logic ov,
                                    output logic z);
    longint ur, sr;
    ur = longint'(a) - longint'(b) - longint'(bin);
    sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    d  = ur[31:0];
    bo = (ur < 0);
    ov = (sr > SMAX) || (sr < SMIN);
    z  = (d == 32'd0);
  endfunction

  // Transaction-level model: 0 idle, 1 busy (m_cnt cycles left), 2 result held.
  int          m_state = 0;
  int          m_cnt = 0;
  logic [31:0] m_diff = '0, p_diff = '0;
  logic        m_bout = 0, m_ovf = 0, m_zero = 0;
  logic        p_bout = 0, p_ovf = 0, p_zero = 0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_state = 0; m_cnt = 0;
      m_diff = '0; m_bout = 0; m_ovf = 0; m_zero = 0;
    end else begin
      case (m_state)
        0: if (valid_i) begin
          model_sub(din1_i, din2_i, bin_i, p_diff, p_bout, p_ovf, p_zero);
          m_cnt   = STEPS;
          m_state = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_state = 2;
            m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf; m_zero = p_zero;
          end
        end
        default: if (ready_i) m_state = 0;
      endcase
    end
  end

  // Per-cycle compare; in RUN the low nibbles already finished show the new result.
  always @(negedge clk_i) begin
    logic [63:0] mask;
    logic [31:0] exp_diff;
    exp_diff = m_diff;
    if (m_state == 1) begin
      mask     = (64'd1 << (4 * (STEPS - m_cnt))) - 64'd1;
      exp_diff = (m_diff & ~mask[31:0]) | (p_diff & mask[31:0]);
    end
    chk("mon_ready", ready_o, m_state == 0);
    chk("mon_valid", valid_o, m_state == 2);
    chk("mon_diff", diff_o, exp_diff);
    chk("mon_bout", bout_o, m_bout);
    chk("mon_ovf", ovf_o, m_ovf);
    chk("mon_zero", zero_o, m_zero);
  end

  task automatic junk_inputs();
    valid_i = 1'($urandom_range(0, 1));
    din1_i  = $urandom;
    din2_i  = $urandom;
    bin_i   = 1'($urandom_range(0, 1));
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
    int n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk_i); #1; n++;
    end
    if (!ready_o) chk("ready_timeout", 0, 1);
    valid_i = 1'b1; din1_i = a; din2_i = b; bin_i = bin;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      junk_inputs();
      @(posedge clk_i); #1;
      lat++;
    end while (!valid_o && lat < 40);
    valid_i = 1'b0;
    if (!valid_o) chk("done_timeout", 0, 1);
  endtask

  task automatic consume(input int hold, input logic keep_valid);
    repeat (hold) begin
      ready_i = 1'b0;
      junk_inputs();
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    valid_i = keep_valid;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic bin, input logic [31:0] ed, input logic ebo,
                         input logic eov, input logic ez);
    int lat;
    start_op(a, b, bin);
    wait_done(lat);
    chk({name, "_lat"}, lat, STEPS);
    chk({name, "_diff"}, diff_o, ed);
    chk({name, "_bout"}, bout_o, ebo);
    chk({name, "_ovf"}, ovf_o, eov);
    chk({name, "_zero"}, zero_o, ez);
    consume(0, 1'b0);
  endtask

  task automatic pin_model(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic bin, input logic [31:0] ed, input logic ebo,
                           input logic eov, input logic ez);
    logic [31:0] d;
    logic bo, ov, z;
    model_sub(a, b, bin, d, bo, ov, z);
    chk({name, "_mdl"}, {d, bo, ov, z}, {ed, ebo, eov, ez});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    logic [31:0] a, b;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_diff", diff_o, 0);
    rst_ni = 1'b1;

    pin_model("v038", 32'h5, 32'h3, 1'b0, 32'h2, 0, 0, 0);
    pin_model("v039", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1, 0, 0);
    pin_model("v040a", 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 0, 1, 0);
    pin_model("v040b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1, 1, 0);
    pin_model("v041", 32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0, 0, 0, 1);

    run_lit("d038", 32'h5, 32'h3, 1'b0, 32'h2, 0, 0, 0);
    run_lit("d039", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1, 0, 0);
    run_lit("d040a", 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 0, 1, 0);
    run_lit("d040b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1, 1, 0);
    run_lit("d041", 32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0, 0, 0, 1);

    // Backpressure: result must stay frozen while requests are offered.
    start_op(32'h5, 32'h3, 1'b0);
    wait_done(lat);
    repeat (5) begin
      ready_i = 1'b0; valid_i = 1'b1; din1_i = $urandom; din2_i = $urandom;
      bin_i = 1'($urandom_range(0, 1));
      @(posedge clk_i); #1;
      chk("bp_diff", diff_o, 32'h2);
      chk("bp_ready", ready_o, 0);
      chk("bp_valid", valid_o, 1);
    end
    ready_i = 1'b1; valid_i = 1'b1; din1_i = 32'h10; din2_i = 32'h1; bin_i = 1'b0;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk("bp_idle_ready", ready_o, 1);
    chk("bp_idle_valid", valid_o, 0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("bp_accept", ready_o, 0);
    wait_done(lat);
    chk("bp_next_diff", diff_o, 32'hF);
    consume(0, 1'b0);

    // Asynchronous reset after step 3 of an operation.
    start_op(32'hDEAD_BEEF, 32'h1, 1'b0);
    repeat (4) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("ar_ready", ready_o, 1);
    chk("ar_valid", valid_o, 0);
    chk("ar_diff", diff_o, 0);
    chk("ar_flags", {bout_o, ovf_o, zero_o}, 3'b000);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_lit("d043", 32'h10, 32'h1, 1'b0, 32'hF, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      a = pick_operand();
      b = ($urandom_range(0, 7) == 0) ? a : pick_operand();
      start_op(a, b, 1'($urandom_range(0, 1)));
      wait_done(lat);
      chk("rnd_lat", lat, STEPS);
      consume($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i); #1;
      end
    end

    @(posedge clk_i); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub32_serial.md
SUB32_SERIAL -- requirements
Module: sub32_serial

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived: STEPS = WIDTH/4, the number of nibble cycles per operation.
REQ-003 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 Port: valid_i  in  1  request valid.
REQ-006 Port: ready_o  out  1  block can accept a request.
REQ-007 Port: din1_i  in  WIDTH  minuend.
REQ-008 Port: din2_i  in  WIDTH  subtrahend.
REQ-009 Port: bin_i  in  1  borrow-in, active-high.
REQ-010 Port: valid_o  out  1  result valid.
REQ-011 Port: ready_i  in  1  consumer accepts the result.
REQ-012 Port: diff_o  out  WIDTH  difference, din1_i - din2_i - bin_i, modulo 2^WIDTH.
REQ-013 Port: bout_o  out  1  unsigned borrow-out, high when din1_i < din2_i + bin_i.
REQ-014 Port: ovf_o  out  1  two's-complement signed overflow.
REQ-015 Port: zero_o  out  1  diff_o equals 0.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 ready_o SHALL be 1 only in IDLE; valid_o SHALL be 1 only in DONE.
REQ-018 Accept: IDLE and valid_i=1 -> on the edge, latch din1_i, din2_i and bin_i, set step=0, set borrow=bin_i, go to RUN.
REQ-019 While ready_o=0, the block SHALL ignore valid_i, din1_i, din2_i and bin_i.
REQ-020 RUN, each edge: compute nibble k as a[4k+3:4k] + ~b[4k+3:4k] + ~borrow in a 5-bit sum.
REQ-021 RUN, same edge: store the low 4 bits of that sum into diff[4k+3:4k]; set borrow to the inverse of bit 4.
REQ-022 RUN, same edge: increment step; on the edge that processes step=STEPS-1, go to DONE.
REQ-023 Latency: valid_o SHALL rise exactly STEPS cycles after the accept edge (8 cycles for WIDTH=32).
REQ-024 On entry to DONE: bout_o = final borrow.
REQ-025 On entry to DONE: ovf_o = (a[MSB] != b[MSB]) and (diff[MSB] != a[MSB]).
REQ-026 On entry to DONE: zero_o = (diff == 0).
REQ-027 DONE with ready_i=0: diff_o, bout_o, ovf_o, zero_o and valid_o SHALL hold unchanged.
REQ-028 DONE with ready_i=1: return to IDLE on the edge.
REQ-029 No new request SHALL be accepted in the cycle the result is consumed; the minimum issue interval is STEPS+2 cycles.
REQ-030 diff_o, bout_o, ovf_o and zero_o SHALL be registered outputs.
REQ-031 Outside DONE, result outputs SHALL retain their last values; only valid_o qualifies them.
REQ-032 diff_o SHALL be updated incrementally, one nibble per RUN cycle.
REQ-033 Operands SHALL be treated both as unsigned (bout_o) and as two's complement (ovf_o); no saturation.

Reset
REQ-034 rst_ni=0 SHALL immediately force IDLE, step=0, borrow=0, diff_o=0, bout_o=0, ovf_o=0, zero_o=0, valid_o=0.
REQ-035 Under reset, ready_o SHALL be 1, following state IDLE.
REQ-036 Reset asserted in RUN or DONE SHALL abort the operation; no partial result is ever flagged valid.
REQ-037 After rst_ni rises, the first edge with valid_i=1 SHALL be accepted.

Verification
REQ-038 0x00000005 - 0x00000003, bin=0 -> diff 0x00000002, bout 0, ovf 0, zero 0; valid_o 8 cycles after accept.
REQ-039 0x00000000 - 0x00000001, bin=0 -> diff 0xFFFFFFFF, bout 1, ovf 0, zero 0.
REQ-040 0x80000000 - 0x00000001, bin=0 -> diff 0x7FFFFFFF, bout 0, ovf 1; and 0x7FFFFFFF - 0xFFFFFFFF -> diff 0x80000000, bout 1, ovf 1.
REQ-041 0x12345678 - 0x12345677, bin=1 -> diff 0x00000000, bout 0, ovf 0, zero 1.
REQ-042 Backpressure: hold ready_i=0 for 5 cycles in DONE while toggling valid_i and operands -> outputs stable, ready_o=0, no accept.
REQ-042a Backpressure, continued: ready_i=1 -> IDLE next edge; the next accept is no earlier than 1 cycle later.
REQ-043 Reset mid-RUN (after step 3): pulse rst_ni low asynchronously -> all outputs 0 and ready_o=1 immediately.
REQ-043a Reset mid-RUN, continued: after release, a fresh 0x00000010 - 0x00000001 request yields diff 0x0000000F, bout 0.
